// File: rtl/vault_top_module.sv
// vault_top_module: five-phase vault puzzle sequencer (keypad, direction, colour, pattern, code/key).
// Optional feature: define VAULT_LOCKOUT_EN to send every phase back to IDLE on a wrong entry.
module vault_top_module #(
    parameter logic [3:0] KEYPAD_KEY  = 4'b0011,
    parameter logic [2:0] DIR_KEY     = 3'b010,
    parameter logic [3:0] COLOR_KEY   = 4'b0010,
    parameter logic [7:0] PATTERN_KEY = 8'h55,
    parameter logic [3:0] CODE_KEY    = 4'b1010,
    parameter logic [3:0] FINAL_KEY   = 4'b0101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_input,
    input  logic [2:0] direction_input,
    input  logic [3:0] color_input,
    input  logic [7:0] pattern_input,
    input  logic [3:0] code_input,
    input  logic [3:0] final_key_input,
    output logic       vault_escape,
    output logic       all_done
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} phase_t;
    phase_t     st [5];
    logic [4:0] sec;
    logic [4:0] ones;
    logic [4:0] act;
    logic       lock;

    // Classify each phase input and pick the lowest phase not yet DONE as the active one
    always_comb begin
        sec  = {code_input == CODE_KEY && final_key_input == FINAL_KEY, pattern_input == PATTERN_KEY,
                color_input == COLOR_KEY, direction_input == DIR_KEY, keypad_input == KEYPAD_KEY};
        ones = {&code_input && &final_key_input, &pattern_input, &color_input, &direction_input, &keypad_input};
        act[0] = st[0] != DONE;
        for (int i = 1; i < 5; i++) act[i] = st[i] != DONE && st[i-1] == DONE;
    end

`ifdef VAULT_LOCKOUT_EN
    logic [4:0] zero;
    assign zero = {{code_input, final_key_input} == 8'd0, pattern_input == 8'd0,
                   color_input == 4'd0, direction_input == 3'd0, keypad_input == 4'd0};
    assign lock = |(act & ~sec & ~ones & ~zero);
`else
    assign lock = 1'b0;
`endif

    assign all_done = st[0] == DONE && st[1] == DONE && st[2] == DONE && st[3] == DONE && st[4] == DONE;

    // Step the active phase, clear all phases on lockout, latch escape once everything is done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) st[i] <= IDLE;
            vault_escape <= 1'b0;
        end else begin
            vault_escape <= vault_escape | all_done;
            for (int i = 0; i < 5; i++) begin
                if (lock) st[i] <= IDLE;
                else if (act[i] && st[i] == IDLE && sec[i]) st[i] <= ARMED;
                else if (act[i] && st[i] == ARMED && ones[i]) st[i] <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_vault_top_module.sv
// tb_vault_top_module: randomized and directed bench for vault_top_module against a progress-counter model.
module tb_vault_top_module;
    localparam logic [3:0] KP = 4'b0011;
    localparam logic [2:0] DK = 3'b010;
    localparam logic [3:0] CK = 4'b0010;
    localparam logic [7:0] PK = 8'h55;
    localparam logic [3:0] CD = 4'b1010;
    localparam logic [3:0] FK = 4'b0101;

    logic       clk, rst;
    logic [3:0] keypad_input, color_input, code_input, final_key_input;
    logic [2:0] direction_input;
    logic [7:0] pattern_input;
    logic       vault_escape, all_done;

    int tests = 0;
    int fails = 0;
    int mp;
    bit marm, mesc, ms, mo, mz;

    vault_top_module #(
        .KEYPAD_KEY(KP), .DIR_KEY(DK), .COLOR_KEY(CK),
        .PATTERN_KEY(PK), .CODE_KEY(CD), .FINAL_KEY(FK)
    ) dut (
        .clk(clk), .rst(rst),
        .keypad_input(keypad_input), .direction_input(direction_input),
        .color_input(color_input), .pattern_input(pattern_input),
        .code_input(code_input), .final_key_input(final_key_input),
        .vault_escape(vault_escape), .all_done(all_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, a, e, $time);
        end
    endtask

    // Model: mp counts completed phases in order, marm says the current phase has seen its secret
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mp = 0; marm = 0; mesc = 0;
        end else begin
            mesc = mesc | (mp == 5);
            if (mp < 5) begin
                case (mp)
                    0: begin ms = keypad_input == KP; mo = keypad_input == 4'hF; mz = keypad_input == 4'h0; end
                    1: begin ms = direction_input == DK; mo = direction_input == 3'h7; mz = direction_input == 3'h0; end
                    2: begin ms = color_input == CK; mo = color_input == 4'hF; mz = color_input == 4'h0; end
                    3: begin ms = pattern_input == PK; mo = pattern_input == 8'hFF; mz = pattern_input == 8'h00; end
                    default: begin
                        ms = code_input == CD && final_key_input == FK;
                        mo = code_input == 4'hF && final_key_input == 4'hF;
                        mz = code_input == 4'h0 && final_key_input == 4'h0;
                    end
                endcase
                if (ms) marm = 1;
                else if (mo) begin
                    if (marm) begin mp = mp + 1; marm = 0; end
                end else if (!mz) begin
`ifdef VAULT_LOCKOUT_EN
                    mp = 0; marm = 0;
`endif
                end
            end
        end
    end

    // Every cycle the outputs must match the model
    always @(negedge clk) begin
        chk("cyc_all_done", all_done, mp == 5);
        chk("cyc_vault_escape", vault_escape, mesc);
    end

    task automatic zero_in();
        keypad_input = 0; direction_input = 0; color_input = 0;
        pattern_input = 0; code_input = 0; final_key_input = 0;
    endtask

    // kind: 0 secret, 1 all-ones, 2 zero
    task automatic set_phase(input int ph, input int kind);
        case (ph)
            0: keypad_input = kind == 0 ? KP : kind == 1 ? 4'hF : 4'h0;
            1: direction_input = kind == 0 ? DK : kind == 1 ? 3'h7 : 3'h0;
            2: color_input = kind == 0 ? CK : kind == 1 ? 4'hF : 4'h0;
            3: pattern_input = kind == 0 ? PK : kind == 1 ? 8'hFF : 8'h00;
            default: begin
                code_input = kind == 0 ? CD : kind == 1 ? 4'hF : 4'h0;
                final_key_input = kind == 0 ? FK : kind == 1 ? 4'hF : 4'h0;
            end
        endcase
    endtask

    task automatic drv_phase(input int ph, input int kind, input int reps);
        repeat (reps) begin
            @(negedge clk);
            zero_in();
            set_phase(ph, kind);
        end
    endtask

    task automatic go(input int n);
        for (int ph = 0; ph < n; ph++) begin
            drv_phase(ph, 0, 1);
            drv_phase(ph, 1, 1);
        end
    endtask

    task automatic reset_pulse();
        #2 rst = 0;
        #1;
        chk("async_rst_all_done", all_done, 1'b0);
        chk("async_rst_escape", vault_escape, 1'b0);
        zero_in();
        #1 rst = 1;
    endtask

    initial begin
        rst = 0;
        zero_in();
        repeat (3) @(negedge clk);
        chk("reset_all_done", all_done, 1'b0);
        chk("reset_escape", vault_escape, 1'b0);
        rst = 1;
        repeat (10) @(negedge clk);
        chk("idle_all_done", all_done, 1'b0);
        chk("idle_escape", vault_escape, 1'b0);

        go(5);
        @(negedge clk);
        chk("min_latency_all_done", all_done, 1'b1);
        chk("escape_lags_one_cycle", vault_escape, 1'b0);
        @(negedge clk);
        chk("escape_set", vault_escape, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_all_done", all_done, 1'b1);
        chk("hold_escape", vault_escape, 1'b1);
        reset_pulse();

        for (int ph = 0; ph < 5; ph++) begin
            drv_phase(ph, 0, 2);
            drv_phase(ph, 1, 2);
        end
        @(negedge clk);
        chk("happy_all_done", all_done, 1'b1);
        chk("happy_escape", vault_escape, 1'b1);
        reset_pulse();

        drv_phase(1, 0, 1);
        drv_phase(1, 1, 1);
        drv_phase(0, 0, 1);
        drv_phase(0, 1, 1);
        drv_phase(1, 1, 1);
        for (int ph = 2; ph < 5; ph++) begin
            drv_phase(ph, 0, 1);
            drv_phase(ph, 1, 1);
        end
        @(negedge clk);
        chk("out_of_order_all_done", all_done, 1'b0);
        reset_pulse();

        go(4);
        @(negedge clk);
        zero_in();
        code_input = CD;
        drv_phase(4, 1, 1);
        @(negedge clk);
        chk("partial_match_all_done", all_done, 1'b0);
        reset_pulse();

        go(1);
        drv_phase(1, 0, 1);
        @(negedge clk);
        zero_in();
        direction_input = 3'b001;
        drv_phase(1, 1, 1);
        for (int ph = 2; ph < 5; ph++) begin
            drv_phase(ph, 0, 1);
            drv_phase(ph, 1, 1);
        end
        @(negedge clk);
`ifdef VAULT_LOCKOUT_EN
        chk("lockout_all_done", all_done, 1'b0);
`else
        chk("no_lockout_all_done", all_done, 1'b1);
`endif
        go(5);
        @(negedge clk);
        chk("replay_all_done", all_done, 1'b1);
        reset_pulse();

        go(3);
        reset_pulse();
        go(5);
        @(negedge clk);
        chk("after_mid_reset_all_done", all_done, 1'b1);
        reset_pulse();

        for (int n = 0; n < 1500; n++) begin
            int r;
            @(negedge clk);
            keypad_input = 4'($urandom);
            direction_input = 3'($urandom);
            color_input = 4'($urandom);
            pattern_input = 8'($urandom);
            code_input = 4'($urandom);
            final_key_input = 4'($urandom);
            r = $urandom_range(9, 0);
            if (mp < 5) begin
                if (r < 4) set_phase(mp, 0);
                else if (r < 7) set_phase(mp, 1);
                else if (r < 8) set_phase(mp, 2);
                else if (r == 8 && mp == 4) begin
                    set_phase(4, 2);
                    code_input = CD;
                end
            end
            if ($urandom_range(149, 0) == 0) reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
